conv3x3_engine: RTL
===================

# conv3x3_engine

Sequential 3x3 binary-image convolution engine, the compute stage directly downstream of the switch-driven row loader. It captures a 6x6 binary image and a 3x3 signed kernel on a start pulse. It computes the 16 valid-position outputs (4x4) in raster order using one multiply-accumulate per cycle. Each result is streamed out over a valid/ready handshake to the display/readout stage.

## Interface
- W, 4: kernel weight width, signed two's complement; accumulator width ACC_W = W+4 (derived, not overridable)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset rst_n, asynchronous, active-low; clock clk
- start  input  1  begin a frame; honoured only in IDLE
- img_in  input  36  image; row r = img_in[6r+5:6r], column c = bit c of that slice; 1 = pixel set
- kern_in  input  9*W  weights; weight k (k = 3*kr + kc) = kern_in[W*k+W-1:W*k]
- busy  output  1  high from the cycle after start is accepted until return to IDLE
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  ACC_W  signed convolution result
- out_row  output  2  output row 0..3
- out_col  output  2  output column 0..3
- out_last  output  1  high with out_valid for position (3,3)
- done  output  1  single-cycle pulse after final handshake

## Operation
- States: IDLE, MAC, OUT.
- IDLE with start=1: register img_in and kern_in; set pos=0, k=0, acc=0; enter MAC. Later changes on img_in/kern_in do not affect the frame.
- MAC, one tap per cycle for k = 0..8:
  - kr = k/3, kc = k%3.
  - Add weight k (sign-extended to ACC_W) to acc if pixel (out_row+kr, out_col+kc) is 1; otherwise add 0.
  - At k=8, load out_data with the final sum, assert out_valid, and enter OUT.
- OUT: out_data, out_row, out_col and out_last are held stable while out_valid=1 and out_ready=0.
  - On handshake (out_valid & out_ready), drop out_valid.
  - If pos=15: pulse done next cycle and go to IDLE.
  - Otherwise: pos+1, k=0, acc=0, go to MAC.
- pos is raster ordered: out_row = pos[3:2], out_col = pos[1:0].
- Arithmetic range: |sum| ≤ 9·2^(W-1), which fits ACC_W with no overflow possible. Output is the exact signed sum.
- start while busy is ignored: no restart and no effect on the captured data.
- Reset, including mid-frame, forces:
  - state IDLE;
  - busy, out_valid, out_last and done = 0;
  - out_data, out_row and out_col = 0;
  - pos, k and acc = 0.
  - The partial frame is discarded and no done pulse is issued.

## Timing
- Start accepted at edge T0: busy=1 and the first MAC tap happen at T1; out_valid rises after edge T9.
- With out_ready held high, each output occupies 10 cycles (9 MAC + 1 OUT); a frame takes 160 cycles from start to the final handshake.
- done is high for exactly one cycle, the cycle after the final handshake edge, together with busy=0.
- start is sampled in the same cycle done is high and can launch the next frame immediately (IDLE is already entered).
- out_ready may be asserted before out_valid; the handshake still takes only the single OUT cycle.
- No combinational path from out_ready to any output.

## Configuration
- CONV_RELU_EN defined: out_data = max(sum, 0); negative sums are emitted as 0. Accumulation is unchanged.
- CONV_RELU_EN undefined: out_data is the raw signed sum.

## Test plan
- All-ones image, all weights +1, out_ready=1: 16 outputs of 9, raster order (0,0)..(3,3), out_last only on (3,3); done 160 cycles after start.
- Single pixel at (0,0), weight 0 = 7, others 0: out(0,0)=7, all other outputs 0.
- All-ones image, all weights -8 (W=4): every output -72. With CONV_RELU_EN: every output 0.
- out_ready low for 5 cycles on output 5: out_valid, out_data and out_row/out_col stay stable; the stream resumes with no loss or duplication.
- start pulsed mid-frame with a different img_in: ignored, and the frame results match the originally captured image. rst_n low mid-frame: all outputs zero immediately, no done pulse; a new start runs the full frame correctly.
- start high in the done cycle: a second frame begins without an idle gap, and busy re-asserts the next cycle.

Source files
------------

// File: rtl/conv3x3_engine_if.sv
// Result stream interface for conv3x3_engine: valid/ready handshake plus payload.
interface conv3x3_engine_if #(
    parameter int unsigned W = 4
) ();
    localparam int unsigned ACC_W = W + 4;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [1:0]              out_row;
    logic [1:0]              out_col;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/conv3x3_engine.sv
// Sequential 3x3 binary-image convolution: 6x6 image, 4x4 outputs, one MAC per cycle.
// Optional feature macro: CONV_RELU_EN (clamp negative results to zero on output).
module conv3x3_engine #(
    parameter int unsigned W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [35:0]       img_in,
    input  logic [9*W-1:0]    kern_in,
    output logic              busy,
    output logic              done,
    conv3x3_engine_if.master  o_out
);
    localparam int unsigned ACC_W  = W + 4;
    localparam int unsigned KERN_W = 9 * W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]              r_state, w_state_nxt;
    logic [35:0]             r_img, w_img_nxt;
    logic [KERN_W-1:0]       r_kern, w_kern_nxt;
    logic [3:0]              r_pos, w_pos_nxt;
    logic [3:0]              r_k, w_k_nxt;
    logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
    logic signed [ACC_W-1:0] r_data, w_data_nxt;
    logic                    r_valid, w_valid_nxt;
    logic                    r_last, w_last_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_done, w_done_nxt;

    logic [1:0]              w_kr, w_kc;
    logic [2:0]              w_pr, w_pc;
    logic [5:0]              w_pix_idx;
    logic                    w_pix;
    logic signed [W-1:0]     w_wt;
    logic signed [ACC_W-1:0] w_tap, w_sum, w_res;

    // Current tap: locate the image pixel and kernel weight, form the partial sum
    always_comb begin
        w_kr      = 2'(r_k / 4'd3);
        w_kc      = 2'(r_k % 4'd3);
        w_pr      = 3'(r_pos[3:2]) + 3'(w_kr);
        w_pc      = 3'(r_pos[1:0]) + 3'(w_kc);
        w_pix_idx = 6'(w_pr) * 6'd6 + 6'(w_pc);
        w_pix     = r_img[w_pix_idx];
        w_wt      = r_kern[W*32'(r_k) +: W];
        w_tap     = w_pix ? ACC_W'(w_wt) : '0;
        w_sum     = r_acc + w_tap;
`ifdef CONV_RELU_EN
        w_res     = w_sum[ACC_W-1] ? '0 : w_sum;
`else
        w_res     = w_sum;
`endif
    end

    // Next-state and next-output logic for IDLE -> MAC -> OUT sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_img_nxt   = r_img;
        w_kern_nxt  = r_kern;
        w_pos_nxt   = r_pos;
        w_k_nxt     = r_k;
        w_acc_nxt   = r_acc;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_img_nxt   = img_in;
                    w_kern_nxt  = kern_in;
                    w_pos_nxt   = 4'd0;
                    w_k_nxt     = 4'd0;
                    w_acc_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                w_acc_nxt = w_sum;
                if (r_k == 4'd8) begin
                    w_data_nxt  = w_res;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (r_pos == 4'd15);
                    w_state_nxt = S_OUT;
                end else begin
                    w_k_nxt = 4'(r_k + 4'd1);
                end
            end
            S_OUT: begin
                if (r_valid && o_out.out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    if (r_pos == 4'd15) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_pos_nxt   = 4'(r_pos + 4'd1);
                        w_k_nxt     = 4'd0;
                        w_acc_nxt   = '0;
                        w_state_nxt = S_MAC;
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_img   <= '0;
            r_kern  <= '0;
            r_pos   <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_img   <= w_img_nxt;
            r_kern  <= w_kern_nxt;
            r_pos   <= w_pos_nxt;
            r_k     <= w_k_nxt;
            r_acc   <= w_acc_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_out.out_valid = r_valid;
    assign o_out.out_data  = r_data;
    assign o_out.out_row   = r_pos[3:2];
    assign o_out.out_col   = r_pos[1:0];
    assign o_out.out_last  = r_last;
    assign busy            = r_busy;
    assign done            = r_done;
endmodule
